// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus memory responder.
// Covers the state encoding, CA field positions and register constants.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_RDATA,
        ST_WDATA,
        ST_REGW
    } state_t;

    localparam int CA_RW       = 47;
    localparam int CA_AS       = 46;
    localparam int CA_BURST    = 45;
    localparam int CA_ROW_MSB  = 44;
    localparam int CA_ROW_LSB  = 16;
    localparam int CA_COL_MSB  = 2;

    localparam logic [15:0] CR0_RESET   = 16'h8F1F;
    localparam int          REG_SEL_BIT = 11;
    localparam int          WRAP_BITS   = 4;

    // Word-address bit REG_SEL_BIT lives in the row field, above the 3 column bits.
    localparam int REG_SEL_CA = CA_ROW_LSB + REG_SEL_BIT - (CA_COL_MSB + 1);

endpackage

// File: rtl/hyperram_target_if.sv
// HyperBus pin bundle between a controller (master) and the memory responder (slave).
interface hyperram_target_if;
    logic       ram_cs;
    logic       ram_ck;
    logic [7:0] ram_adq_i;
    logic [7:0] ram_adq_o;
    logic       ram_adq_oe;
    logic       ram_rwds_i;
    logic       ram_rwds_o;
    logic       ram_rwds_oe;

    modport master (
        output ram_cs, ram_ck, ram_adq_i, ram_rwds_i,
        input  ram_adq_o, ram_adq_oe, ram_rwds_o, ram_rwds_oe
    );

    modport slave (
        input  ram_cs, ram_ck, ram_adq_i, ram_rwds_i,
        output ram_adq_o, ram_adq_oe, ram_rwds_o, ram_rwds_oe
    );
endinterface

// File: rtl/hyperbus_ca_decode.sv
// Command-address shift register and field extraction.
// Fields are taken from the post-shift value so the last CA byte is usable on its own edge.
module hyperbus_ca_decode
    import hyperbus_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_shift,
    input  logic [7:0]    i_byte,
    output logic          o_is_read,
    output logic          o_is_reg,
    output logic          o_is_linear,
    output logic          o_reg_sel,
    output logic [AW-1:0] o_addr
);
    logic [47:0] r_sr;
    logic [47:0] w_ca;

    assign w_ca = i_shift ? {r_sr[39:0], i_byte} : r_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sr <= '0;
        else if (i_shift)
            r_sr <= w_ca;
    end

    assign o_is_read   = w_ca[CA_RW];
    assign o_is_reg    = w_ca[CA_AS];
    assign o_is_linear = w_ca[CA_BURST];
    assign o_reg_sel   = w_ca[REG_SEL_CA];
    assign o_addr      = AW'({w_ca[CA_ROW_MSB:CA_ROW_LSB], w_ca[CA_COL_MSB:0]});
endmodule

// File: rtl/hyperram_target.sv
// HyperBus memory responder: CA decode, fixed 2x latency, linear/wrapped bursts, ID/CR0 registers.
// state    | meaning
// IDLE     | chip deselected, outputs released
// CA       | shifting in 6 command-address bytes, latency indicator driven
// LAT      | counting initial latency edges up to the first data edge
// RDATA    | driving read bytes with rwds strobe
// WDATA    | writing masked bytes into the array
// REGW     | zero-latency CR0 load on edges 6-7
module hyperram_target
    import hyperbus_pkg::*;
#(
    parameter int          AW      = 10,
    parameter int          LATENCY = 6,
    parameter logic [15:0] ID0     = 16'h0C81
) (
    input logic              clk,
    input logic              rst,
    hyperram_target_if.slave bus
);
    localparam int D0 = 4 * LATENCY + 4;
    localparam int EW = $clog2(D0 + 1);

    state_t          r_state;
    logic            r_ck_q;
    logic [EW-1:0]   r_e;
    logic            r_lo;
    logic [AW-1:0]   r_addr;
    logic [15:0]     r_cr0;
    logic [7:0]      r_adq_o;
    logic            r_adq_oe;
    logic            r_rwds_o;
    logic            r_rwds_oe;
    logic [15:0]     r_mem [0:2**AW-1];

    logic            w_edge;
    logic            w_ca_shift;
    logic            w_is_read;
    logic            w_is_reg;
    logic            w_is_linear;
    logic            w_reg_sel;
    logic [AW-1:0]   w_ca_addr;
    logic [AW-1:0]   w_addr_inc;
    logic [15:0]     w_word;
    logic            w_we_hi;
    logic            w_we_lo;

    assign w_edge     = (bus.ram_ck != r_ck_q) && !bus.ram_cs;
    assign w_ca_shift = w_edge && (r_state == ST_IDLE || r_state == ST_CA);

    hyperbus_ca_decode #(.AW(AW)) u_ca (
        .clk         (clk),
        .rst         (rst),
        .i_shift     (w_ca_shift),
        .i_byte      (bus.ram_adq_i),
        .o_is_read   (w_is_read),
        .o_is_reg    (w_is_reg),
        .o_is_linear (w_is_linear),
        .o_reg_sel   (w_reg_sel),
        .o_addr      (w_ca_addr)
    );

    // Wrapped bursts stay inside a 16-word aligned group.
    assign w_addr_inc = w_is_linear ? r_addr + 1'b1
                                    : {r_addr[AW-1:WRAP_BITS], r_addr[WRAP_BITS-1:0] + 1'b1};
    assign w_word     = w_is_reg ? (w_reg_sel ? r_cr0 : ID0) : r_mem[r_addr];

    assign w_we_hi = (r_state == ST_WDATA) && w_edge && !r_lo && !bus.ram_rwds_i;
    assign w_we_lo = (r_state == ST_WDATA) && w_edge &&  r_lo && !bus.ram_rwds_i;

    always_ff @(posedge clk) begin
        if (w_we_hi)
            r_mem[r_addr][15:8] <= bus.ram_adq_i;
        if (w_we_lo)
            r_mem[r_addr][7:0] <= bus.ram_adq_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ck_q    <= 1'b0;
            r_e       <= '0;
            r_lo      <= 1'b0;
            r_addr    <= '0;
            r_cr0     <= CR0_RESET;
            r_adq_o   <= '0;
            r_adq_oe  <= 1'b0;
            r_rwds_o  <= 1'b0;
            r_rwds_oe <= 1'b0;
        end else begin
            r_ck_q <= bus.ram_ck;
            if (bus.ram_cs) begin
                r_state   <= ST_IDLE;
                r_e       <= '0;
                r_lo      <= 1'b0;
                r_adq_o   <= '0;
                r_adq_oe  <= 1'b0;
                r_rwds_o  <= 1'b0;
                r_rwds_oe <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_CA;
                        r_rwds_oe <= 1'b1;
                        r_rwds_o  <= 1'b1;
                        r_e       <= w_edge ? EW'(1) : '0;
                    end
                    ST_CA: if (w_edge) begin
                        r_e <= r_e + 1'b1;
                        if (r_e == EW'(5)) begin
                            r_rwds_oe <= 1'b0;
                            r_rwds_o  <= 1'b0;
                            r_state   <= (!w_is_read && w_is_reg) ? ST_REGW : ST_LAT;
                        end
                    end
                    ST_REGW: if (w_edge) begin
                        if (r_e == EW'(6))
                            r_cr0[15:8] <= bus.ram_adq_i;
                        if (r_e == EW'(7))
                            r_cr0[7:0] <= bus.ram_adq_i;
                        if (r_e != EW'(D0))
                            r_e <= r_e + 1'b1;
                    end
                    ST_LAT: if (w_edge) begin
                        r_e <= r_e + 1'b1;
                        if (r_e == EW'(D0 - 1)) begin
                            r_addr  <= w_ca_addr;
                            r_lo    <= 1'b0;
                            r_state <= w_is_read ? ST_RDATA : ST_WDATA;
                            if (w_is_read) begin
                                r_adq_oe  <= 1'b1;
                                r_rwds_oe <= 1'b1;
                                r_rwds_o  <= 1'b0;
                            end
                        end
                    end
                    ST_RDATA: if (w_edge) begin
                        r_adq_o  <= r_lo ? w_word[7:0] : w_word[15:8];
                        r_rwds_o <= !r_lo;
                        r_lo     <= !r_lo;
                        if (r_lo && !w_is_reg)
                            r_addr <= w_addr_inc;
                    end
                    ST_WDATA: if (w_edge) begin
                        r_lo <= !r_lo;
                        if (r_lo)
                            r_addr <= w_addr_inc;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ram_adq_o   = r_adq_o;
    assign bus.ram_adq_oe  = r_adq_oe;
    assign bus.ram_rwds_o  = r_rwds_o;
    assign bus.ram_rwds_oe = r_rwds_oe;
endmodule

// File: tb/tb_hyperram_target.sv
// Scoreboard bench for hyperram_target: read bytes are queued when each data edge is driven
// and compared on the cycle after the responder detects that edge.
module tb_hyperram_target;
    localparam int          AW  = 10;
    localparam int          D0  = 4 * 6 + 4;
    localparam logic [15:0] ID0 = 16'h0C81;

    logic clk;
    logic rst;
    hyperram_target_if bus();

    hyperram_target #(.AW(AW), .LATENCY(6), .ID0(ID0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_bad;
    logic [8:0]  exp_q[$];
    bit          chk_next;
    logic [15:0] mem_m [0:1023];
    logic [15:0] m_cr0;
    logic [15:0] wbuf [0:15];
    logic [1:0]  mbuf [0:15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic sample_pending();
        logic [8:0] e;
        if (chk_next) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
            chk("rd_data", 32'({bus.ram_adq_oe, bus.ram_rwds_o, bus.ram_adq_o}), 32'({1'b1, e}));
        end
        chk_next = 1'b0;
    endtask

    task automatic step(input logic [7:0] b, input logic m, input bit rd);
        @(posedge clk); #1;
        sample_pending();
        chk_next       = rd;
        bus.ram_ck     = ~bus.ram_ck;
        bus.ram_adq_i  = b;
        bus.ram_rwds_i = m;
    endtask

    task automatic xfer(input bit rd, input bit rg, input bit lin, input logic [31:0] a,
                        input int n, input int abort_at);
        logic [47:0]   ca;
        logic [AW-1:0] wa;
        logic [15:0]   w;
        logic [7:0]    b;
        logic          m;
        ca = {rd, rg, lin, a[31:3], 13'd0, a[2:0]};
        wa = a[AW-1:0];
        @(posedge clk); #1;
        bus.ram_cs = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(ca[47-8*k -: 8], 1'b0, 1'b0);
            if (k == 0)
                chk("lat_ind", 32'({bus.ram_rwds_oe, bus.ram_rwds_o, bus.ram_adq_oe}), 32'(3'b110));
        end
        if (rg && !rd) begin
            w = wbuf[0];
            step(w[15:8], 1'b0, 1'b0);
            chk("lat_rel", 32'({bus.ram_rwds_oe, bus.ram_adq_oe}), 32'(0));
            step(w[7:0], 1'b0, 1'b0);
            m_cr0 = w;
        end else begin
            for (int k = 6; k < D0; k++) begin
                step(8'h00, 1'b0, 1'b0);
                if (k == 6)
                    chk("lat_rel", 32'({bus.ram_rwds_oe, bus.ram_adq_oe}), 32'(0));
            end
            for (int i = 0; i < 2 * n; i++) begin
                if (i == abort_at) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_clr", 32'({bus.ram_adq_o, bus.ram_adq_oe, bus.ram_rwds_o, bus.ram_rwds_oe}), 32'(0));
                    exp_q.delete();
                    chk_next = 1'b0;
                    m_cr0    = 16'h8F1F;
                    @(posedge clk); #1;
                    rst        = 1'b0;
                    bus.ram_cs = 1'b1;
                    return;
                end
                if (rd) begin
                    w = rg ? (a[11] ? m_cr0 : ID0) : mem_m[wa];
                    b = i[0] ? w[7:0] : w[15:8];
                    m = 1'b0;
                    exp_q.push_back({~i[0], b});
                end else begin
                    w = wbuf[i/2];
                    b = i[0] ? w[7:0] : w[15:8];
                    m = i[0] ? mbuf[i/2][0] : mbuf[i/2][1];
                end
                step(b, m, rd);
                if (rd && i == 0)
                    chk("preamble", 32'({bus.ram_adq_oe, bus.ram_rwds_oe, bus.ram_rwds_o}), 32'(3'b110));
                if (!rd && !m) begin
                    if (i[0]) mem_m[wa][7:0] = b;
                    else      mem_m[wa][15:8] = b;
                end
                if (i[0] && !(rd && rg))
                    wa = lin ? wa + 1'b1 : {wa[AW-1:4], wa[3:0] + 4'd1};
            end
        end
        @(posedge clk); #1;
        sample_pending();
        bus.ram_cs = 1'b1;
        @(posedge clk); #1;
        chk("release", 32'({bus.ram_adq_oe, bus.ram_rwds_oe}), 32'(0));
    endtask

    task automatic clear_mask();
        for (int i = 0; i < 16; i++) mbuf[i] = 2'b00;
    endtask

    initial begin
        logic [47:0] ca;
        n_chk          = 0;
        n_bad          = 0;
        chk_next       = 1'b0;
        m_cr0          = 16'h8F1F;
        rst            = 1'b1;
        bus.ram_cs     = 1'b1;
        bus.ram_ck     = 1'b0;
        bus.ram_adq_i  = 8'h00;
        bus.ram_rwds_i = 1'b0;
        clear_mask();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'({bus.ram_adq_o, bus.ram_adq_oe, bus.ram_rwds_o, bus.ram_rwds_oe}), 32'(0));
        rst = 1'b0;

        xfer(1'b1, 1'b1, 1'b1, 32'h800, 1, -1);

        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        xfer(1'b0, 1'b0, 1'b1, 32'h010, 4, -1);
        xfer(1'b1, 1'b0, 1'b1, 32'h010, 4, -1);

        for (int i = 0; i < 16; i++) wbuf[i] = 16'(32 + i);
        xfer(1'b0, 1'b0, 1'b1, 32'h020, 16, -1);
        xfer(1'b1, 1'b0, 1'b0, 32'h02E, 18, -1);

        wbuf[0] = 16'hFFFF;
        xfer(1'b0, 1'b0, 1'b1, 32'h005, 1, -1);
        wbuf[0] = 16'hAB12; mbuf[0] = 2'b01;
        xfer(1'b0, 1'b0, 1'b1, 32'h005, 1, -1);
        clear_mask();
        xfer(1'b1, 1'b0, 1'b1, 32'h005, 1, -1);
        chk("mask_model", 32'(mem_m[5]), 32'(16'hABFF));

        wbuf[0] = 16'h8F17;
        xfer(1'b0, 1'b1, 1'b1, 32'h800, 1, -1);
        xfer(1'b1, 1'b1, 1'b1, 32'h800, 2, -1);
        xfer(1'b1, 1'b1, 1'b1, 32'h000, 1, -1);

        ca = {3'b001, 29'd0, 13'd0, 3'd5};
        @(posedge clk); #1;
        bus.ram_cs = 1'b0;
        for (int k = 0; k < 4; k++) step(ca[47-8*k -: 8], 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("early_pre", 32'(bus.ram_rwds_oe), 32'(1));
        bus.ram_cs = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step(8'h55, 1'b0, 1'b0);
            if (k == 0)
                chk("early_rel", 32'({bus.ram_adq_oe, bus.ram_rwds_oe}), 32'(0));
        end
        xfer(1'b1, 1'b0, 1'b1, 32'h005, 1, -1);

        xfer(1'b1, 1'b0, 1'b1, 32'h010, 4, 3);
        xfer(1'b1, 1'b0, 1'b1, 32'h010, 4, -1);
        xfer(1'b1, 1'b1, 1'b1, 32'h800, 1, -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
